// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 round controller.
// Holds the controller state encoding, round constants and the GF(2^8) xtime helper.
package aes128_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRound,
        StFinal,
        StDone
    } ctrl_state_t;

    localparam int unsigned NR = 10;
    localparam int unsigned NK = 4;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    // Multiply by x in GF(2^8), reducing by the AES polynomial on carry-out.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_rcon_gen.sv
// Registered round-constant generator for the AES-128 key schedule.
// clr has priority over load, and load has priority over step.
module aes128_rcon_gen
    import aes128_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic       step,
    output logic [7:0] rcon
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcon <= 8'h00;
        end else if (clr) begin
            rcon <= 8'h00;
        end else if (load) begin
            rcon <= RCON_INIT;
        end else if (step) begin
            rcon <= xtime(rcon);
        end
    end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Sequencer for the AES-128 round datapath: initial AddRoundKey, rounds 1-9, final round.
// All outputs are registered; each round lasts ROUND_LAT cycles.
module aes128_round_ctrl
    import aes128_pkg::*;
#(
    parameter int unsigned ROUND_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [3:0] round,
    output logic [7:0] rcon,
    output logic       load_in,
    output logic       key_load,
    output logic       key_step,
    output logic       state_en,
    output logic       mix_en
);

    localparam logic [1:0] CntLast     = 2'(ROUND_LAT - 1);
    localparam logic       FirstIsLast = (ROUND_LAT == 1);

    ctrl_state_t state_q;
    logic [1:0]  cnt_q;
    logic        last_cyc;
    logic        next_last;
    logic        abort_hit;
    logic        rcon_clr;
    logic        rcon_load;
    logic        rcon_step;

    assign last_cyc  = (cnt_q == CntLast);
    assign next_last = ((cnt_q + 2'd1) == CntLast);
    assign abort_hit = abort && (state_q != StIdle);

    // RCON tracks the round register: loaded on entry to round 1, stepped on each round advance.
    assign rcon_clr  = abort_hit || (state_q == StDone);
    assign rcon_load = (state_q == StInit) && !abort;
    assign rcon_step = (state_q == StRound) && last_cyc && !abort;

    aes128_rcon_gen u_rcon_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rcon_clr),
        .load  (rcon_load),
        .step  (rcon_step),
        .rcon  (rcon)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            round    <= 4'd0;
            load_in  <= 1'b0;
            key_load <= 1'b0;
            key_step <= 1'b0;
            state_en <= 1'b0;
            mix_en   <= 1'b0;
        end else begin
            load_in  <= 1'b0;
            key_load <= 1'b0;
            key_step <= 1'b0;
            state_en <= 1'b0;
            done     <= 1'b0;
            if (abort_hit) begin
                state_q <= StIdle;
                cnt_q   <= 2'd0;
                busy    <= 1'b0;
                round   <= 4'd0;
                mix_en  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !abort) begin
                            state_q  <= StInit;
                            busy     <= 1'b1;
                            load_in  <= 1'b1;
                            key_load <= 1'b1;
                            state_en <= 1'b1;
                        end
                    end
                    StInit: begin
                        state_q  <= StRound;
                        round    <= 4'd1;
                        cnt_q    <= 2'd0;
                        mix_en   <= 1'b1;
                        state_en <= FirstIsLast;
                        key_step <= FirstIsLast;
                    end
                    StRound, StFinal: begin
                        if (!last_cyc) begin
                            cnt_q    <= cnt_q + 2'd1;
                            state_en <= next_last;
                            key_step <= next_last;
                        end else if (state_q == StFinal) begin
                            state_q <= StDone;
                            cnt_q   <= 2'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            mix_en  <= 1'b0;
                        end else begin
                            cnt_q    <= 2'd0;
                            round    <= round + 4'd1;
                            state_en <= FirstIsLast;
                            key_step <= FirstIsLast;
                            if (round == 4'(NR - 1)) begin
                                state_q <= StFinal;
                                mix_en  <= 1'b0;
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        round   <= 4'd0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl: two instances (ROUND_LAT=1 and 3) share stimulus and are
// compared every cycle against a timeline model keyed on the cycle each block started.
module tb_aes128_round_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    logic       busy_w     [2];
    logic       done_w     [2];
    logic [3:0] round_w    [2];
    logic [7:0] rcon_w     [2];
    logic       load_in_w  [2];
    logic       key_load_w [2];
    logic       key_step_w [2];
    logic       state_en_w [2];
    logic       mix_en_w   [2];

    // {busy, done, round[3:0], rcon[7:0], load_in, key_load, key_step, state_en, mix_en}
    logic [18:0] act [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t0     [2];

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    always #5 clk = ~clk;

    aes128_round_ctrl #(.ROUND_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy_w[0]), .done(done_w[0]), .round(round_w[0]), .rcon(rcon_w[0]),
        .load_in(load_in_w[0]), .key_load(key_load_w[0]), .key_step(key_step_w[0]),
        .state_en(state_en_w[0]), .mix_en(mix_en_w[0])
    );

    aes128_round_ctrl #(.ROUND_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy_w[1]), .done(done_w[1]), .round(round_w[1]), .rcon(rcon_w[1]),
        .load_in(load_in_w[1]), .key_load(key_load_w[1]), .key_step(key_step_w[1]),
        .state_en(state_en_w[1]), .mix_en(mix_en_w[1])
    );

    assign act[0] = {busy_w[0], done_w[0], round_w[0], rcon_w[0], load_in_w[0],
                     key_load_w[0], key_step_w[0], state_en_w[0], mix_en_w[0]};
    assign act[1] = {busy_w[1], done_w[1], round_w[1], rcon_w[1], load_in_w[1],
                     key_load_w[1], key_step_w[1], state_en_w[1], mix_en_w[1]};

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Expected outputs d cycles after the INIT cycle of a block (d<0: idle).
    function automatic logic [18:0] exp_of(input int lat, input int d);
        logic [18:0] e;
        int r, pos;
        e = '0;
        if (d == 0) begin
            e = {1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        end else if (d >= 1 && d <= 10 * lat) begin
            r   = (d - 1) / lat + 1;
            pos = (d - 1) % lat;
            e = {1'b1, 1'b0, 4'(r), rcon_tab[r-1], 1'b0, 1'b0,
                 (pos == lat - 1), (pos == lat - 1), (r != 10)};
        end else if (d == 10 * lat + 1) begin
            e = {1'b0, 1'b1, 4'd10, 8'h36, 5'b00000};
        end
        return e;
    endfunction

    function automatic logic [18:0] exp_now(input int i);
        return (t0[i] < 0) ? 19'd0 : exp_of(lat_of(i), cyc - t0[i]);
    endfunction

    // One clock edge: advance the model with the inputs seen at the edge, then settle.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) t0[i] = -1;
            else if (t0[i] >= 0) begin
                if (abort || (cyc - t0[i]) == 10 * lat_of(i) + 1) t0[i] = -1;
            end else if (start && !abort) t0[i] = cyc + 1;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        t0[0] = -1;
        t0[1] = -1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act[i] !== 19'd0) begin
                errors++;
                $display("FAIL reset_async lat=%0d got=%h want=%h", lat_of(i), act[i], 19'd0);
            end
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_now(i)) begin
                    errors++;
                    $display("FAIL reset_idle lat=%0d cyc=%0d got=%h want=%h",
                             lat_of(i), cyc, act[i], exp_now(i));
                end
            end
        end
    endtask

    task automatic test_nominal();
        int base, se, ks, kl, li;
        int done_at [2];
        int dn [2];
        base = cyc;
        se = 0; ks = 0; kl = 0; li = 0;
        done_at = '{-1, -1};
        dn = '{0, 0};
        start = 1'b1;
        for (int n = 0; n < 35; n++) begin
            if (n == 1) start = 1'b0;
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_now(i)) begin
                    errors++;
                    $display("FAIL nominal lat=%0d cyc=%0d got=%h want=%h",
                             lat_of(i), cyc - base, act[i], exp_now(i));
                end
                if (done_w[i]) begin
                    dn[i]++;
                    if (done_at[i] < 0) done_at[i] = cyc - base;
                end
            end
            se += int'(state_en_w[0]);
            ks += int'(key_step_w[0]);
            kl += int'(key_load_w[0]);
            li += int'(load_in_w[0]);
            if (state_en_w[0] && round_w[0] != 4'd0 && round_w[0] <= 4'd10) begin
                checks++;
                if (rcon_w[0] !== rcon_tab[round_w[0]-1]) begin
                    errors++;
                    $display("FAIL rcon round=%0d got=%h want=%h",
                             round_w[0], rcon_w[0], rcon_tab[round_w[0]-1]);
                end
            end
        end
        checks++;
        if (done_at[0] !== 12) begin
            errors++; $display("FAIL done_cycle_lat1 got=%0d want=12", done_at[0]);
        end
        checks++;
        if (done_at[1] !== 32) begin
            errors++; $display("FAIL done_cycle_lat3 got=%0d want=32", done_at[1]);
        end
        checks++;
        if (dn[0] !== 1 || dn[1] !== 1) begin
            errors++; $display("FAIL done_count got=%0d,%0d want=1,1", dn[0], dn[1]);
        end
        checks++;
        if (se !== 11) begin errors++; $display("FAIL state_en_count got=%0d want=11", se); end
        checks++;
        if (ks !== 10) begin errors++; $display("FAIL key_step_count got=%0d want=10", ks); end
        checks++;
        if (kl !== 1 || li !== 1) begin
            errors++; $display("FAIL load_counts got=%0d,%0d want=1,1", kl, li);
        end
    endtask

    task automatic test_start_while_busy();
        int base;
        int dq [$];
        base = cyc;
        for (int n = 0; n < 40; n++) begin
            start = (n == 0 || n == 5 || n == 14);
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_now(i)) begin
                    errors++;
                    $display("FAIL start_busy lat=%0d cyc=%0d got=%h want=%h",
                             lat_of(i), cyc - base, act[i], exp_now(i));
                end
            end
            if (done_w[0]) dq.push_back(cyc - base);
        end
        start = 1'b0;
        checks++;
        if (dq.size() != 2 || dq[0] != 12 || dq[1] != 26) begin
            errors++;
            $display("FAIL start_busy_done got_n=%0d first=%0d want=2 at 12,26",
                     dq.size(), (dq.size() > 0) ? dq[0] : -1);
        end
    endtask

    task automatic test_abort();
        int base;
        int dq [2][$];
        base = cyc;
        for (int n = 0; n < 45; n++) begin
            start = (n == 0 || n == 8);
            abort = (n == 6);
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_now(i)) begin
                    errors++;
                    $display("FAIL abort lat=%0d cyc=%0d got=%h want=%h",
                             lat_of(i), cyc - base, act[i], exp_now(i));
                end
                if (done_w[i]) dq[i].push_back(cyc - base);
            end
            if (n == 6) begin
                checks++;
                if (act[0] !== 19'd0) begin
                    errors++; $display("FAIL abort_outputs got=%h want=%h", act[0], 19'd0);
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (dq[0].size() != 1 || dq[0][0] != 20) begin
            errors++;
            $display("FAIL abort_done_lat1 got_n=%0d want single at 20", dq[0].size());
        end
        checks++;
        if (dq[1].size() != 1 || dq[1][0] != 40) begin
            errors++;
            $display("FAIL abort_done_lat3 got_n=%0d want single at 40", dq[1].size());
        end
    endtask

    task automatic test_reset_mid();
        int base, done_at;
        base = cyc;
        start = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            start = 1'b0;
        end
        checks++;
        if (round_w[0] !== 4'd4) begin
            errors++; $display("FAIL reset_mid_round got=%0d want=4", round_w[0]);
        end
        #3 rst_n = 1'b0;
        t0[0] = -1;
        t0[1] = -1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act[i] !== 19'd0) begin
                errors++;
                $display("FAIL reset_mid lat=%0d got=%h want=%h", lat_of(i), act[i], 19'd0);
            end
        end
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_now(i)) begin
                    errors++;
                    $display("FAIL reset_mid_idle lat=%0d got=%h want=%h",
                             lat_of(i), act[i], exp_now(i));
                end
            end
        end
        base = cyc;
        done_at = -1;
        start = 1'b1;
        for (int n = 0; n < 14; n++) begin
            tick();
            start = 1'b0;
            checks++;
            if (act[0] !== exp_now(0)) begin
                errors++;
                $display("FAIL reset_mid_rerun cyc=%0d got=%h want=%h",
                         cyc - base, act[0], exp_now(0));
            end
            if (done_w[0] && done_at < 0) done_at = cyc - base;
        end
        checks++;
        if (done_at !== 12) begin
            errors++; $display("FAIL reset_mid_done got=%0d want=12", done_at);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 29) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_now(i)) begin
                    errors++;
                    $display("FAIL random lat=%0d cyc=%0d start=%0b abort=%0b got=%h want=%h",
                             lat_of(i), cyc, start, abort, act[i], exp_now(i));
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        t0[0] = -1;
        t0[1] = -1;
        test_reset();
        test_nominal();
        test_start_while_busy();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
Sequencer for the AES-128 encryption round datapath: SubBytes, ShiftRows, MixColumns, AddRoundKey and the key-schedule register.
- Accepts a START request and steps the datapath through the initial AddRoundKey, rounds 1–9 (with MixColumns) and round 10 (MixColumns bypassed).
- Drives per-round enables, the round number and RCON to the key schedule.
- Signals completion with a one-cycle DONE pulse.
- Sits between the top-level AES wrapper and the round datapath; it handles no data bytes itself.

Parameters:
- ROUND_LAT, 1, cycles per round through the datapath (legal 1..4; the registered shiftrow stage gives 1).
- NR, 10, number of AES rounds (fixed for AES-128; not overridden).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  request to begin one block encryption; sampled only in IDLE
- ABORT  in  1  cancel the current operation; returns to IDLE
- BUSY  out  1  high from INIT through FINAL inclusive
- DONE  out  1  one-cycle pulse; ciphertext valid in the datapath state register
- ROUND  out  4  current round, 0..10
- RCON  out  8  round constant for the current round's key expansion
- LOAD_IN  out  1  mux plaintext (not round output) into the state register
- KEY_LOAD  out  1  load the cipher key into the key-schedule register
- KEY_STEP  out  1  advance the key schedule one round using RCON
- STATE_EN  out  1  capture enable for the datapath state register
- MIX_EN  out  1  1 = use MixColumns output, 0 = bypass (final round)

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE; all outputs 0; ROUND=0; RCON=8'h00; internal cycle counter=0.
- States: IDLE, INIT, ROUND, FINAL, DONE_S.
- IDLE:
  - START=1 and ABORT=0 -> INIT.
  - Otherwise stay; all outputs 0.
- INIT (1 cycle):
  - LOAD_IN=1, KEY_LOAD=1, STATE_EN=1, ROUND=0, BUSY=1.
  - Datapath performs plaintext XOR key0.
  - -> ROUND with ROUND=1.
- ROUND (rounds 1..9):
  - Each round lasts ROUND_LAT cycles; MIX_EN=1 throughout.
  - STATE_EN=1 and KEY_STEP=1 only on the last cycle of the round.
  - ROUND then increments; when ROUND becomes 10 -> FINAL.
- FINAL (round 10): same as ROUND but MIX_EN=0. After its STATE_EN cycle -> DONE_S.
- DONE_S (1 cycle):
  - DONE=1, BUSY=0, ROUND=10 held.
  - -> IDLE unconditionally; START in this cycle is ignored.
- RCON per round:
  - 1..10 -> 01,02,04,08,10,20,40,80,1B,36.
  - 8'h00 when ROUND=0 or IDLE.
  - Computed by xtime, i.e. shift left with conditional XOR 8'h1B on MSB carry.
- Latency: START sampled at edge k -> DONE high in cycle k+2+10*ROUND_LAT. With ROUND_LAT=1, START at cycle 0 gives INIT at 1, rounds at 2..11, DONE at 12.
- START while BUSY: ignored; no queueing.
- ABORT in any non-IDLE state:
  - Next state IDLE; all outputs 0 the following cycle; no DONE.
  - ABORT wins over START in the same cycle.
- Reset mid-operation: immediate return to reset values; no DONE.
- STATE_EN pulses exactly 11 times per completed block; KEY_STEP exactly 10; KEY_LOAD and LOAD_IN exactly once.
- Outputs are registered (Moore); no combinational path from START/ABORT to outputs.

Decomposition:
- Shared package aes128_pkg holds:
  - state encoding enum ctrl_state_t;
  - constants NR=10, NK=4;
  - RCON_INIT=8'h01, RCON_POLY=8'h1B;
  - function xtime(8-bit).
- One sub-module, aes128_rcon_gen:
  - registered RCON generator;
  - load (to 01) and step (xtime) controls;
  - clear to 00 on reset, ABORT and IDLE entry.
- Controller FSM plus cycle counter stay in aes128_round_ctrl.

Test Plan:
1. Reset release, START=1 at cycle 0, ROUND_LAT=1 -> INIT with LOAD_IN/KEY_LOAD at cycle 1; ROUND 1..10 at cycles 2..11; MIX_EN=0 only at cycle 11; DONE=1 at cycle 12 only.
2. Same run, log RCON per round -> 01,02,04,08,10,20,40,80,1B,36; STATE_EN count=11; KEY_STEP count=10.
3. ROUND_LAT=3, START -> each ROUND value held 3 cycles with STATE_EN only on the third; DONE at cycle 32.
4. START pulsed at cycle 5 mid-run -> no effect; single DONE at cycle 12; a new START at cycle 14 gives DONE at cycle 26.
5. ABORT=1 at cycle 6 (ROUND=5) -> cycle 7 all outputs 0 and ROUND=0; no DONE ever; START at cycle 8 runs cleanly to DONE at cycle 20.
6. RST_N low mid-cycle during round 4 -> outputs 0 immediately, without waiting for a CLK edge; after release, idle until START.
